// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider: width default,
// sequencer states and the controller state encodings.
package div_pkg;

  localparam int DIV_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // Controller encodings; the datapath only sees the levels decoded from them.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } ctl_state_t;

  function automatic logic any_level(input logic ld_data, input logic ld_r,
                                     input logic dec_r, input logic ld_q,
                                     input logic inc_q);
    return ld_data | ld_r | dec_r | ld_q | inc_q;
  endfunction

endpackage

// File: rtl/div_stage_reg.sv
// Single-entry holding register with a full flag; used for the operand
// stage and for the result slot.
module div_stage_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic [DW-1:0] dout
);

  logic          full_reg;
  logic [DW-1:0] data_reg;

  // Data only moves on load, so the held value is stable while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (load) begin
      full_reg <= 1'b1;
      data_reg <= din;
    end else if (clear) begin
      full_reg <= 1'b0;
    end
  end

  assign full = full_reg;
  assign dout = data_reg;

endmodule

// File: rtl/div_datapath.sv
// Datapath and job sequencer for the repeated-subtraction divider: working
// registers driven by the controller levels, plus operand/result handshakes.
module div_datapath
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_dividend,
  input  logic [W-1:0] in_divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_quotient,
  output logic [W-1:0] out_remainder,
  output logic         out_dbz,
  output logic         ctl_rst,
  input  logic         ldData,
  input  logic         ldR,
  input  logic         decR,
  input  logic         ldQ,
  input  logic         incQ,
  output logic         gte
);

  logic           stage_full;
  logic [2*W-1:0] stage_data;
  logic [W-1:0]   stage_dividend;
  logic [W-1:0]   stage_divisor;
  logic           in_fire;

  assign in_ready       = !stage_full;
  assign in_fire        = in_valid && in_ready;
  assign stage_dividend = stage_data[2*W-1:W];
  assign stage_divisor  = stage_data[W-1:0];

  div_stage_reg #(.DW(2*W)) u_stage (
    .clk   (clk),
    .rst   (rst),
    .load  (in_fire),
    .clear (ldData),
    .din   ({in_dividend, in_divisor}),
    .full  (stage_full),
    .dout  (stage_data)
  );

  logic [W-1:0] r_reg, d_reg, q_reg, tr_reg, tq_reg;

  // ldData takes priority over the R/Q writebacks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg  <= '0;
      d_reg  <= '0;
      q_reg  <= '0;
      tr_reg <= '0;
      tq_reg <= '0;
    end else begin
      if (decR) tr_reg <= r_reg - d_reg;
      if (incQ) tq_reg <= q_reg + W'(1);
      if (ldData) begin
        r_reg <= stage_dividend;
        d_reg <= stage_divisor;
        q_reg <= '0;
      end else begin
        if (ldR) r_reg <= tr_reg;
        if (ldQ) q_reg <= tq_reg;
      end
    end
  end

  assign gte = (r_reg >= d_reg) && (d_reg != '0);

  seq_state_t state_reg;
  logic       ctl_rst_reg;
  logic       seen_load_reg;
  logic       done;

  assign done = (state_reg == RUN) && seen_load_reg && !gte &&
                !any_level(ldData, ldR, decR, ldQ, incQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ctl_rst_reg   <= 1'b1;
      seen_load_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A staged job waits until the previous result has been taken.
          if (stage_full && !out_valid) begin
            state_reg   <= RUN;
            ctl_rst_reg <= 1'b0;
          end
        end
        RUN: begin
          if (ldData) seen_load_reg <= 1'b1;
          if (done) begin
            state_reg     <= IDLE;
            ctl_rst_reg   <= 1'b1;
            seen_load_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          ctl_rst_reg <= 1'b1;
        end
      endcase
    end
  end

  assign ctl_rst = ctl_rst_reg;

  logic [2*W:0] result_data;

  div_stage_reg #(.DW(2*W+1)) u_result (
    .clk   (clk),
    .rst   (rst),
    .load  (done),
    .clear (out_valid && out_ready),
    .din   ({(d_reg == '0), q_reg, r_reg}),
    .full  (out_valid),
    .dout  (result_data)
  );

  assign out_dbz       = result_data[2*W];
  assign out_quotient  = result_data[2*W-1:W];
  assign out_remainder = result_data[W-1:0];

endmodule

// File: tb/tb_div_datapath.sv
// Bench for div_datapath with a small model of the divider controller
// (S0 idle, S1 load, S2 test, S3 subtract/increment, S4 writeback, S5 done).
module tb_div_datapath;
  import div_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_dividend = '0;
  logic [7:0] in_divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_quotient;
  logic [7:0] out_remainder;
  logic       out_dbz;
  logic       ctl_rst;
  logic       ldData, ldR, decR, ldQ, incQ;
  logic       gte;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int a_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_datapath #(.W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_dbz       (out_dbz),
    .ctl_rst       (ctl_rst),
    .ldData        (ldData),
    .ldR           (ldR),
    .decR          (decR),
    .ldQ           (ldQ),
    .incQ          (incQ),
    .gte           (gte)
  );

  // Controller model, held in S0 while ctl_rst is high.
  ctl_state_t st = S0;
  always @(posedge clk) begin
    if (rst || ctl_rst) st <= S0;
    else begin
      case (st)
        S0: st <= S1;
        S1: st <= S2;
        S2: st <= gte ? S3 : S5;
        S3: st <= S4;
        S4: st <= S2;
        default: st <= S5;
      endcase
    end
  end
  assign ldData = (st == S1);
  assign decR   = (st == S3);
  assign incQ   = (st == S3);
  assign ldR    = (st == S4);
  assign ldQ    = (st == S4);

  // Called at a negedge; the transfer edge is recorded in a_cyc.
  task automatic send_op(input logic [7:0] dd, input logic [7:0] dv);
    int guard = 0;
    while (!in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL send_op: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1; in_dividend = dd; in_divisor = dv;
    a_cyc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int budget, output int lat, output int decs,
                             output int gtes, output int fall);
    bit ok = 1'b0;
    lat = -1; decs = 0; gtes = 0; fall = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        lat = cyc - a_cyc;
        break;
      end
      if (decR) decs++;
      if (gte) gtes++;
      if (!ctl_rst && fall < 0) fall = cyc - a_cyc;
    end
    if (!ok) begin
      checks++; fails++;
      $display("FAIL result_timeout: out_valid=0 after %0d cycles required 1", budget);
    end
    $display("job done: q=%0d r=%0d dbz=%0b latency=%0d", out_quotient, out_remainder, out_dbz, lat);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_dbz !== 1'b0) begin fails++; $display("FAIL reset_out_dbz: got %0b want 0", out_dbz); end
    checks++; if (ctl_rst !== 1'b1) begin fails++; $display("FAIL reset_ctl_rst: got %0b want 1", ctl_rst); end
    checks++; if (gte !== 1'b0) begin fails++; $display("FAIL reset_gte: got %0b want 0", gte); end
    checks++; if (out_quotient !== 8'd0 || out_remainder !== 8'd0) begin
      fails++; $display("FAIL reset_result: got q=%0d r=%0d want 0 0", out_quotient, out_remainder);
    end
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (ctl_rst !== 1'b1) begin fails++; $display("FAIL idle_ctl_rst: got %0b want 1", ctl_rst); end
  endtask

  task automatic test_basic_100_7();
    int lat, decs, gtes, fall;
    send_op(8'd100, 8'd7);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stage_full_in_ready: got %0b want 0", in_ready); end
    wait_result(200, lat, decs, gtes, fall);
    checks++; if (fall !== 1) begin fails++; $display("FAIL ctl_rst_fall: got a+%0d want a+1", fall); end
    checks++; if (lat !== 46) begin fails++; $display("FAIL lat_100_7: got %0d want 46", lat); end
    checks++; if (out_quotient !== 8'd14) begin fails++; $display("FAIL q_100_7: got %0d want 14", out_quotient); end
    checks++; if (out_remainder !== 8'd2) begin fails++; $display("FAIL r_100_7: got %0d want 2", out_remainder); end
    checks++; if (out_dbz !== 1'b0) begin fails++; $display("FAIL dbz_100_7: got %0b want 0", out_dbz); end
    checks++; if (decs !== 14) begin fails++; $display("FAIL decr_100_7: got %0d want 14", decs); end
    take_result();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL out_valid_clear: got %0b want 0", out_valid); end
  endtask

  task automatic test_small_5_9();
    int lat, decs, gtes, fall;
    send_op(8'd5, 8'd9);
    wait_result(200, lat, decs, gtes, fall);
    checks++; if (lat !== 4) begin fails++; $display("FAIL lat_5_9: got %0d want 4", lat); end
    checks++; if (out_quotient !== 8'd0 || out_remainder !== 8'd5) begin
      fails++; $display("FAIL qr_5_9: got q=%0d r=%0d want 0 5", out_quotient, out_remainder);
    end
    checks++; if (decs !== 0) begin fails++; $display("FAIL decr_5_9: got %0d want 0", decs); end
    take_result();
  endtask

  task automatic test_dbz_13_0();
    int lat, decs, gtes, fall;
    send_op(8'd13, 8'd0);
    wait_result(200, lat, decs, gtes, fall);
    checks++; if (lat !== 4) begin fails++; $display("FAIL lat_13_0: got %0d want 4", lat); end
    checks++; if (out_quotient !== 8'd0 || out_remainder !== 8'd13) begin
      fails++; $display("FAIL qr_13_0: got q=%0d r=%0d want 0 13", out_quotient, out_remainder);
    end
    checks++; if (out_dbz !== 1'b1) begin fails++; $display("FAIL dbz_13_0: got %0b want 1", out_dbz); end
    checks++; if (gtes !== 0) begin fails++; $display("FAIL gte_13_0: got %0d high cycles want 0", gtes); end
    take_result();
    checks++; if (out_dbz !== 1'b1) begin fails++; $display("FAIL dbz_hold_after_take: got %0b want 1", out_dbz); end
  endtask

  task automatic test_max_255_1();
    int lat, decs, gtes, fall;
    send_op(8'd255, 8'd1);
    wait_result(2000, lat, decs, gtes, fall);
    checks++; if (lat !== 769) begin fails++; $display("FAIL lat_255_1: got %0d want 769", lat); end
    checks++; if (out_quotient !== 8'd255 || out_remainder !== 8'd0) begin
      fails++; $display("FAIL qr_255_1: got q=%0d r=%0d want 255 0", out_quotient, out_remainder);
    end
    checks++; if (out_dbz !== 1'b0) begin fails++; $display("FAIL dbz_255_1: got %0b want 0", out_dbz); end
    take_result();
  endtask

  task automatic test_back_to_back();
    int lat, decs, gtes, fall;
    bit stable = 1'b1;
    bit held = 1'b1;
    send_op(8'd20, 8'd3);
    wait_result(200, lat, decs, gtes, fall);
    checks++; if (lat !== 22) begin fails++; $display("FAIL lat_20_3: got %0d want 22", lat); end
    checks++; if (out_quotient !== 8'd6 || out_remainder !== 8'd2) begin
      fails++; $display("FAIL qr_20_3: got q=%0d r=%0d want 6 2", out_quotient, out_remainder);
    end
    send_op(8'd9, 8'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || out_quotient !== 8'd6 || out_remainder !== 8'd2) stable = 1'b0;
      if (ctl_rst !== 1'b1) held = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin fails++; $display("FAIL hold_stable: got %0b want 1", stable); end
    checks++; if (held !== 1'b1) begin fails++; $display("FAIL hold_ctl_rst: got %0b want 1", held); end
    take_result();
    a_cyc = cyc;
    wait_result(200, lat, decs, gtes, fall);
    checks++; if (fall !== 1) begin fails++; $display("FAIL b2b_ctl_rst_fall: got t+%0d want t+1", fall); end
    checks++; if (lat !== 10) begin fails++; $display("FAIL lat_9_4: got %0d want 10", lat); end
    checks++; if (out_quotient !== 8'd2 || out_remainder !== 8'd1) begin
      fails++; $display("FAIL qr_9_4: got q=%0d r=%0d want 2 1", out_quotient, out_remainder);
    end
    take_result();
  endtask

  task automatic test_reset_abort();
    int lat, decs, gtes, fall;
    bit quiet = 1'b1;
    send_op(8'd100, 8'd7);
    while (cyc < a_cyc + 10) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_dbz !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL abort_handshake: got ov=%0b dbz=%0b ir=%0b want 0 0 1", out_valid, out_dbz, in_ready);
    end
    checks++; if (ctl_rst !== 1'b1 || gte !== 1'b0) begin
      fails++; $display("FAIL abort_ctl: got ctl_rst=%0b gte=%0b want 1 0", ctl_rst, gte);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid || !ctl_rst) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin fails++; $display("FAIL abort_no_result: got %0b want 1", quiet); end
    send_op(8'd8, 8'd2);
    wait_result(200, lat, decs, gtes, fall);
    checks++; if (lat !== 16) begin fails++; $display("FAIL lat_8_2: got %0d want 16", lat); end
    checks++; if (out_quotient !== 8'd4 || out_remainder !== 8'd0) begin
      fails++; $display("FAIL qr_8_2: got q=%0d r=%0d want 4 0", out_quotient, out_remainder);
    end
    take_result();
  endtask

  initial begin
    test_reset();
    test_basic_100_7();
    test_small_5_9();
    test_dbz_13_0();
    test_max_255_1();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
